sisc_prog_loader: RTL

- Boot-time program loader sitting directly upstream of the sisc instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory write port at consecutive addresses.
- After the last word, asserts CPU_RUN, which the top level uses to release the processor core from reset so fetch starts at PC 0.

---
 rtl/sisc_prog_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sisc_prog_loader.sv
// Boot loader: byte stream -> big-endian 32-bit words -> instruction memory, then CPU_RUN.
// Latency: IM_WE pulses on the edge accepting a word's 4th byte; CPU_RUN one edge after DONE entry.
// Backpressure: IN_READY high in HDR_HI/HDR_LO/DATA (1 byte/cycle), low once DONE or ERR.
module sisc_prog_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 65535
) (
  input  logic              CLK,
  input  logic              RST_F,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_WADDR,
  output logic [31:0]       IM_WDATA,
  output logic              CPU_RUN,
  output logic              BUSY,
  output logic              ERR
);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_count;
  logic [1:0]        r_lane;
  logic [15:0]       r_word_cnt;
  logic [23:0]       r_asm;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_cpu_run;

  logic              w_ready;
  logic              w_accept;
  logic [15:0]       w_hdr_count;
  logic              w_word_done;
  logic              w_last_word;

  assign w_ready     = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_DATA);
  assign w_accept    = IN_VALID && w_ready;
  // Full count as it will be once the low header byte is latched.
  assign w_hdr_count = {r_count[15:8], IN_DATA};
  assign w_word_done = (r_state == S_DATA) && w_accept && (r_lane == 2'd3);
  assign w_last_word = (r_word_cnt == (r_count - 16'd1));

  // State register; reset aborts any load in progress.
  always_ff @(posedge CLK) begin
    if (RST_F) r_state <= S_HDR_HI;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode: header parse, word completion, terminal states.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR_HI: if (w_accept) w_state_nxt = S_HDR_LO;
      S_HDR_LO: begin
        if (w_accept) begin
          if ({16'd0, w_hdr_count} > MAX_WORDS) w_state_nxt = S_ERR;
          else if (w_hdr_count == 16'd0)        w_state_nxt = S_DONE;
          else                                  w_state_nxt = S_DATA;
        end
      end
      S_DATA:   if (w_word_done && w_last_word) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_DONE;
      S_ERR:    w_state_nxt = S_ERR;
      default:  w_state_nxt = S_HDR_HI;
    endcase
  end

  // Header count capture, high byte then low byte.
  always_ff @(posedge CLK) begin
    if (RST_F) begin
      r_count <= 16'd0;
    end else if (w_accept && (r_state == S_HDR_HI)) begin
      r_count[15:8] <= IN_DATA;
    end else if (w_accept && (r_state == S_HDR_LO)) begin
      r_count[7:0] <= IN_DATA;
    end
  end

  // Word assembly and memory write port; address/data hold between pulses.
  always_ff @(posedge CLK) begin
    if (RST_F) begin
      r_lane      <= 2'd0;
      r_word_cnt  <= 16'd0;
      r_asm       <= 24'd0;
      r_next_addr <= BASE_ADDR;
      r_we        <= 1'b0;
      r_waddr     <= BASE_ADDR;
      r_wdata     <= 32'd0;
    end else begin
      r_we <= w_word_done;
      if (w_accept && (r_state == S_DATA)) begin
        r_asm  <= {r_asm[15:0], IN_DATA};
        r_lane <= r_lane + 2'd1;
        if (r_lane == 2'd3) begin
          r_wdata     <= {r_asm, IN_DATA};
          r_waddr     <= r_next_addr;
          r_next_addr <= r_next_addr + ADDR_ONE;
          r_word_cnt  <= r_word_cnt + 16'd1;
        end
      end
    end
  end

  // CPU release trails DONE entry by one edge so it never coincides with the last write.
  always_ff @(posedge CLK) begin
    if (RST_F) r_cpu_run <= 1'b0;
    else       r_cpu_run <= (r_state == S_DONE);
  end

  assign IN_READY = w_ready;
  assign IM_WE    = r_we;
  assign IM_WADDR = r_waddr;
  assign IM_WDATA = r_wdata;
  assign CPU_RUN  = r_cpu_run;
  assign BUSY     = (r_state == S_DATA);
  assign ERR      = (r_state == S_ERR);

endmodule
